// File: rtl/cvxif_instr_pkg.sv
// Shared constants for the CV-X-IF coprocessor instruction path.
// The result buffer depth is defined here so the top-level instance and the ALU-side issue logic use the same value.
package cvxif_instr_pkg;

    localparam int unsigned COPRO_RES_BUF_DEPTH = 4;
    localparam int unsigned REG_ADDR_W          = 5;

endpackage

// File: rtl/copro_result_buffer.sv
// Result FIFO between the coprocessor ALU stage and the CV-X-IF result handshake.
// issue_ready_o throttles the issue stage so that every ALU result has a slot when it arrives.
module copro_result_buffer
    import cvxif_instr_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = COPRO_RES_BUF_DEPTH,
    parameter type         hartid_t = logic,
    parameter type         id_t     = logic
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alu_valid_i,
    input  logic [XLEN-1:0]       alu_result_i,
    input  hartid_t               alu_hartid_i,
    input  id_t                   alu_id_i,
    input  logic [REG_ADDR_W-1:0] alu_rd_i,
    input  logic                  alu_we_i,
    output logic                  issue_ready_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [XLEN-1:0]       result_data_o,
    output hartid_t               result_hartid_o,
    output id_t                   result_id_o,
    output logic [REG_ADDR_W-1:0] result_rd_o,
    output logic                  result_we_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                  overflow_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]       data;
        hartid_t               hartid;
        id_t                   id;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
    } entry_t;

    entry_t [DEPTH-1:0] entries_q, entries_d;
    logic   [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic   [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic   [CW-1:0]    count_q, count_d;

    logic   full;
    logic   push;
    logic   pop;
    logic   [CW:0] occ_with_new;
    entry_t alu_entry;
    entry_t head;

    assign alu_entry = '{data: alu_result_i, hartid: alu_hartid_i, id: alu_id_i,
                         rd: alu_rd_i, we: alu_we_i};

    assign full = (count_q == FULL_CNT);
    assign pop  = result_valid_o && result_ready_i;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign push = alu_valid_i && (!full || pop);

    assign overflow_o = alu_valid_i && !push;

    // Conservative: ignores a concurrent pop so the slot is guaranteed next cycle.
    assign occ_with_new  = {1'b0, count_q} + {{CW{1'b0}}, alu_valid_i};
    assign issue_ready_o = (occ_with_new < DEPTH_EXT);

    always_comb begin
        // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (push) begin
            entries_d[wr_ptr_q] = alu_entry;
            wr_ptr_d            = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: storage is a flop array, so clearing it on reset is cheap and removes stale data from the head path.
            entries_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            // NOTE: non-blocking here so every flop samples the pre-edge value of the others.
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign head           = entries_q[rd_ptr_q];
    assign result_valid_o = (count_q != '0);
    assign count_o        = count_q;

    assign result_data_o   = result_valid_o ? head.data   : '0;
    assign result_hartid_o = result_valid_o ? head.hartid : '0;
    assign result_id_o     = result_valid_o ? head.id     : '0;
    assign result_rd_o     = result_valid_o ? head.rd     : '0;
    assign result_we_o     = result_valid_o ? head.we     : 1'b0;

endmodule

// File: tb/tb_copro_result_buffer.sv
// Bench for copro_result_buffer: a reference occupancy model plus an expected-result queue,
// a table of hand-derived cycle vectors for backpressure/full/overflow, and sequences for push, wrap and reset.
module tb_copro_result_buffer;

    localparam int unsigned DEPTH = 4;

    typedef logic [1:0] hart_t;
    typedef logic [3:0] iid_t;

    typedef struct {
        logic [31:0] data;
        hart_t       hart;
        iid_t        id;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    typedef struct {
        bit   valid;
        iid_t id;
        bit   ready;
        int   exp_cnt;
        bit   exp_ir;
        bit   exp_ov;
        bit   head_chk;
        iid_t exp_head;
    } vec_t;

    logic        clk_i;
    logic        rst_ni;
    logic        alu_valid_i;
    logic [31:0] alu_result_i;
    hart_t       alu_hartid_i;
    iid_t        alu_id_i;
    logic [4:0]  alu_rd_i;
    logic        alu_we_i;
    logic        issue_ready_o;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [31:0] result_data_o;
    hart_t       result_hartid_o;
    iid_t        result_id_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    copro_result_buffer #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .hartid_t (hart_t),
        .id_t     (iid_t)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .alu_valid_i     (alu_valid_i),
        .alu_result_i    (alu_result_i),
        .alu_hartid_i    (alu_hartid_i),
        .alu_id_i        (alu_id_i),
        .alu_rd_i        (alu_rd_i),
        .alu_we_i        (alu_we_i),
        .issue_ready_o   (issue_ready_o),
        .result_valid_o  (result_valid_o),
        .result_ready_i  (result_ready_i),
        .result_data_o   (result_data_o),
        .result_hartid_o (result_hartid_o),
        .result_id_o     (result_id_o),
        .result_rd_o     (result_rd_o),
        .result_we_o     (result_we_o),
        .count_o         (count_o),
        .overflow_o      (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned m_cnt    = 0;
    ent_t        sb[$];
    vec_t        vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_alu(input bit v, input logic [31:0] d, input hart_t h,
                             input iid_t id, input logic [4:0] rd, input logic we);
        alu_valid_i  = v;
        alu_result_i = d;
        alu_hartid_i = h;
        alu_id_i     = id;
        alu_rd_i     = rd;
        alu_we_i     = we;
    endtask

    // Samples at the falling edge, compares against the model, then updates it for the coming rising edge.
    task automatic sample();
        bit   pop_m;
        bit   push_m;
        ent_t e;
        @(negedge clk_i);
        pop_m  = (m_cnt != 0) && result_ready_i;
        push_m = alu_valid_i && ((m_cnt < DEPTH) || pop_m);
        check("count", 64'(count_o), 64'(m_cnt));
        check("valid", 64'(result_valid_o), 64'(m_cnt != 0));
        check("issue_ready", 64'(issue_ready_o), 64'((m_cnt + alu_valid_i) < DEPTH));
        check("overflow", 64'(overflow_o), 64'(alu_valid_i && !push_m));
        if (m_cnt == 0) begin
            check("empty_data", 64'(result_data_o), 64'h0);
            check("empty_id", 64'({result_hartid_o, result_id_o, result_rd_o, result_we_o}), 64'h0);
        end
        if (pop_m) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'h1);
            end else begin
                e = sb.pop_front();
                check("out_data", 64'(result_data_o), 64'(e.data));
                check("out_hart", 64'(result_hartid_o), 64'(e.hart));
                check("out_id", 64'(result_id_o), 64'(e.id));
                check("out_rd", 64'(result_rd_o), 64'(e.rd));
                check("out_we", 64'(result_we_o), 64'(e.we));
            end
        end
        if (push_m) begin
            e = '{alu_result_i, alu_hartid_i, alu_id_i, alu_rd_i, alu_we_i};
            sb.push_back(e);
        end
        m_cnt = m_cnt + 32'(push_m) - 32'(pop_m);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input int budget);
        int guard = 0;
        drive_alu(1'b0, '0, '0, '0, '0, 1'b0);
        result_ready_i = 1'b1;
        while (m_cnt != 0 && guard < budget) begin
            sample();
            tick();
            guard++;
        end
        check("drain_done", 64'(m_cnt), 64'h0);
        check("sb_empty", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected $finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // valid, id, ready, exp_cnt, exp_ir, exp_ov, head_chk, exp_head
        vecs[0]  = '{1, 4'd0, 0, 0, 1, 0, 0, 4'd0};
        vecs[1]  = '{1, 4'd1, 0, 1, 1, 0, 1, 4'd0};
        vecs[2]  = '{1, 4'd2, 0, 2, 1, 0, 1, 4'd0};
        vecs[3]  = '{1, 4'd3, 0, 3, 0, 0, 1, 4'd0};
        vecs[4]  = '{0, 4'd0, 0, 4, 0, 0, 1, 4'd0};
        vecs[5]  = '{1, 4'd7, 1, 4, 0, 0, 1, 4'd0};
        vecs[6]  = '{1, 4'd9, 0, 4, 0, 1, 1, 4'd1};
        vecs[7]  = '{0, 4'd0, 0, 4, 0, 0, 1, 4'd1};
        vecs[8]  = '{0, 4'd0, 1, 4, 0, 0, 1, 4'd1};
        vecs[9]  = '{0, 4'd0, 1, 3, 1, 0, 1, 4'd2};
        vecs[10] = '{0, 4'd0, 1, 2, 1, 0, 1, 4'd3};
        vecs[11] = '{0, 4'd0, 1, 1, 1, 0, 1, 4'd7};
        vecs[12] = '{0, 4'd0, 1, 0, 1, 0, 0, 4'd0};

        // Reset and idle
        rst_ni = 1'b0;
        drive_alu(1'b0, '0, '0, '0, '0, 1'b0);
        result_ready_i = 1'b0;
        #12;
        check("rst_valid", 64'(result_valid_o), 64'h0);
        check("rst_count", 64'(count_o), 64'h0);
        check("rst_issue_ready", 64'(issue_ready_o), 64'h1);
        check("rst_data", 64'(result_data_o), 64'h0);
        check("rst_fields", 64'({result_hartid_o, result_id_o, result_rd_o, result_we_o}), 64'h0);
        tick();
        rst_ni = 1'b1;
        sample();
        tick();

        // Single push, visible the next cycle, popped the cycle after
        drive_alu(1'b1, 32'hDEAD_BEEF, 2'd1, 4'd3, 5'd5, 1'b1);
        result_ready_i = 1'b1;
        sample();
        check("single_no_bypass", 64'(result_valid_o), 64'h0);
        tick();
        drive_alu(1'b0, '0, '0, '0, '0, 1'b0);
        sample();
        check("single_data", 64'(result_data_o), 64'hDEAD_BEEF);
        check("single_id", 64'(result_id_o), 64'h3);
        check("single_rd", 64'(result_rd_o), 64'h5);
        check("single_we", 64'(result_we_o), 64'h1);
        tick();
        sample();
        check("single_count_back", 64'(count_o), 64'h0);
        tick();

        // Backpressure fill, full push+pop, overflow, drain
        for (int i = 0; i < 13; i++) begin
            drive_alu(vecs[i].valid, 32'hA500_0000 | 32'(vecs[i].id), hart_t'(i),
                      vecs[i].id, 5'(i), 1'b1);
            result_ready_i = vecs[i].ready;
            sample();
            check($sformatf("vec%0d_count", i), 64'(count_o), 64'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_issue_ready", i), 64'(issue_ready_o), 64'(vecs[i].exp_ir));
            check($sformatf("vec%0d_overflow", i), 64'(overflow_o), 64'(vecs[i].exp_ov));
            if (vecs[i].head_chk) begin
                check($sformatf("vec%0d_head_id", i), 64'(result_id_o), 64'(vecs[i].exp_head));
                check($sformatf("vec%0d_head_data", i), 64'(result_data_o),
                      64'(32'hA500_0000 | 32'(vecs[i].exp_head)));
            end
            tick();
        end
        drain(20);

        // Stream 10 results across pointer wrap, issue gated by the model's view of issue_ready
        begin
            int sent = 0;
            int cyc  = 0;
            while (sent < 10 && cyc < 100) begin
                result_ready_i = (cyc % 2 == 0);
                if ((m_cnt + 1) < DEPTH) begin
                    drive_alu(1'b1, $urandom, hart_t'(sent), iid_t'(sent + 4),
                              5'(sent + 10), logic'(sent % 3 != 0));
                    sent++;
                end else begin
                    drive_alu(1'b0, '0, '0, '0, '0, 1'b0);
                end
                sample();
                tick();
                cyc++;
            end
            check("stream_sent", 64'(sent), 64'd10);
        end
        drain(20);

        // Refill then reset asynchronously mid-cycle
        result_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_alu(1'b1, 32'h5A5A_0000 + 32'(i), 2'd2, iid_t'(i), 5'(i), 1'b1);
            sample();
            tick();
        end
        drive_alu(1'b0, '0, '0, '0, '0, 1'b0);
        sample();
        check("pre_reset_count", 64'(count_o), 64'h3);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 64'(result_valid_o), 64'h0);
        check("async_rst_count", 64'(count_o), 64'h0);
        check("async_rst_data", 64'(result_data_o), 64'h0);
        check("async_rst_fields", 64'({result_hartid_o, result_id_o, result_rd_o, result_we_o}), 64'h0);
        sb.delete();
        m_cnt = 0;
        tick();
        rst_ni = 1'b1;
        sample();
        tick();
        drive_alu(1'b1, 32'hCAFE_F00D, 2'd3, 4'd11, 5'd31, 1'b0);
        sample();
        tick();
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/copro_result_buffer.md
Name: copro_result_buffer

Overview:
- Sits directly downstream of the coprocessor ALU stage and upstream of the CV-X-IF result interface.
- The ALU registers one result per accepted instruction every cycle and has no backpressure. This block absorbs those results in a small FIFO and presents them on a valid/ready result handshake.
- It drives an issue-ready signal back to the issue stage so that no ALU result can ever be lost.

Parameters:
- XLEN, 32, result data width
- DEPTH, 4, number of FIFO entries; power of two, ≥2
- hartid_t, logic, hart identifier type
- id_t, logic, instruction identifier type

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- alu_valid_i  in  1  ALU result valid (one-cycle pulse per result)
- alu_result_i  in  XLEN  ALU result data
- alu_hartid_i  in  hartid_t  hart id of result
- alu_id_i  in  id_t  instruction id of result
- alu_rd_i  in  5  destination register
- alu_we_i  in  1  register write enable (0 for NOP)
- issue_ready_o  out  1  issue stage may send a new instruction to the ALU this cycle
- result_valid_o  out  1  head entry valid
- result_ready_i  in  1  consumer accepts head entry
- result_data_o  out  XLEN  head data
- result_hartid_o  out  hartid_t  head hart id
- result_id_o  out  id_t  head id
- result_rd_o  out  5  head rd
- result_we_o  out  1  head write enable
- count_o  out  $clog2(DEPTH)+1  current occupancy
- overflow_o  out  1  one-cycle pulse: ALU result dropped

Behaviour:
- Reset (async, rst_ni low):
  - pointers and count cleared; storage cleared
  - result_valid_o=0, all result_* outputs=0, count_o=0, overflow_o=0
  - issue_ready_o=1 while alu_valid_i=0
- Storage: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH; count_q tracks occupancy 0..DEPTH.
- push = alu_valid_i && (count_q<DEPTH || pop); pop = result_valid_o && result_ready_i.
- Simultaneous push and pop:
  - count unchanged, both pointers advance
  - allowed when full, because the pop frees the slot in the same cycle
- Latency: a result pushed in cycle N is visible at the outputs from cycle N+1 at the earliest. There is no combinational bypass from alu_* to result_*.
- Head outputs:
  - result_valid_o = (count_q != 0)
  - result_* = entry[rd_ptr] when valid, forced to 0 when empty
  - Outputs must remain stable while result_valid_o=1 && result_ready_i=0.
- NOP results (alu_we_i=0) are stored and forwarded like any other entry; the id must still be retired.
- issue_ready_o = (count_q + alu_valid_i) < DEPTH, computed combinationally and conservatively (ignores pop). This guarantees a free slot for the result one cycle later.
- Overflow: alu_valid_i while full with no pop means the entry is not written. overflow_o pulses high for that cycle and state is unchanged. This is only reachable if the issue stage ignores issue_ready_o; treat it as an assertion-worthy error.
- result_ready_i while empty: no effect.
- Reset mid-operation: all entries discarded immediately, no partial outputs.

Decomposition:
- Add constant COPRO_RES_BUF_DEPTH (=4) to cvxif_instr_pkg; the top-level instance passes it as DEPTH.
- Entry struct {data, hartid, id, rd, we} is declared locally, because hartid_t/id_t are parameters.
- No sub-module; pointer/count logic is inline.

Test Plan:
- Reset then idle → result_valid_o=0, count_o=0, issue_ready_o=1, all result_* = 0.
- Single push: alu_valid_i=1, result=0xDEADBEEF, id=3, rd=5, we=1, result_ready_i=1 → next cycle result_valid_o=1 with 0xDEADBEEF/3/5/1; popped the following cycle, count returns to 0.
- Backpressure: result_ready_i=0, push 4 results (ids 0..3) in consecutive cycles:
  - issue_ready_o drops once count_q+alu_valid_i reaches 4
  - count_o=4
  - head stays id 0 and stable
  - releasing ready drains ids 0,1,2,3 in order, one per cycle
- Full with simultaneous push+pop: count=4, ready=1, alu_valid_i=1 id=7 → count stays 4, no overflow_o; id 7 appears as the fifth output after the current four.
- Overflow: count=4, ready=0, alu_valid_i=1 → overflow_o=1 for one cycle; count stays 4; drained contents exclude the dropped entry.
- Wrap and reset: stream 10 results with ready toggling 1010…, check order and values across pointer wrap; assert rst_ni mid-stream → outputs 0 asynchronously, count_o=0.
